// File: rtl/fme_pkg.sv
// Shared FME sequencing types: barrier-sequencer FSM states and the default run length.
package fme_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_NUM_BLOCKS = 16;

endpackage

// File: rtl/lambdar_barrier_sequencer_if.sv
// Handshake and status bundle between the barrier sequencer (master) and its environment (slave).
interface lambdar_barrier_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 5
);

  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_ready;
  logic                  out_valid;
  logic [NUM_STAGES-1:0] stage_enable;
  logic [CNT_W-1:0]      blk_idx;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, in_valid, out_ready,
    output in_ready, out_valid, stage_enable, blk_idx, busy, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  in_ready, out_valid, stage_enable, blk_idx, busy, done
  );

endinterface

// File: rtl/lambdar_valid_pipe.sv
// Per-stage valid bits of the barrier chain; one stage per cycle, whole chain freezes while
// the last stage holds a result that downstream refuses.
module lambdar_valid_pipe #(
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  logic                  out_ready,
  output logic                  adv,
  output logic                  out_valid,
  output logic [NUM_STAGES-1:0] stage_enable
);

  logic [NUM_STAGES-1:0] v_q;
  logic [NUM_STAGES-1:0] v_d;

  // Kept apart from the shift logic: in_ready depends on adv and accept depends on in_ready.
  assign adv       = !(v_q[NUM_STAGES-1] && !out_ready);
  assign out_valid = v_q[NUM_STAGES-1];

  always_comb begin
    v_d          = v_q;
    stage_enable = '0;
    if (adv) begin
      v_d[0]          = accept;
      stage_enable[0] = accept;
      for (int i = 1; i < NUM_STAGES; i++) begin
        v_d[i]          = v_q[i-1];
        stage_enable[i] = v_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/lambdar_barrier_sequencer.sv
// Sequences one macroblock of NUM_BLOCKS sub-blocks through the lambda-R barrier chain:
// NUM_STAGES-cycle latency, 1 block/cycle, full-chain stall when out_ready is low on a valid output.
module lambdar_barrier_sequencer
  import fme_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int CNT_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lambdar_barrier_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLOCKS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic                  adv;
  logic                  accept;
  logic                  out_vld;
  logic                  out_hs;
  logic                  in_rdy;
  logic [NUM_STAGES-1:0] stage_en;

  assign in_rdy = (state_q == RUN) && adv;
  assign accept = bus.in_valid && in_rdy;
  assign out_hs = out_vld && bus.out_ready;

  lambdar_valid_pipe #(
    .NUM_STAGES (NUM_STAGES)
  ) u_valid_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (accept),
    .out_ready    (bus.out_ready),
    .adv          (adv),
    .out_valid    (out_vld),
    .stage_enable (stage_en)
  );

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (accept) in_cnt_d = in_cnt_q + CNT_W'(1);
    if (out_hs) out_cnt_d = out_cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      RUN: begin
        if (out_hs && out_cnt_q == LAST_BLK)      state_d = DONE;
        else if (accept && in_cnt_q == LAST_BLK)  state_d = DRAIN;
      end
      DRAIN: begin
        if (out_hs && out_cnt_q == LAST_BLK) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = out_vld;
  assign bus.stage_enable = stage_en;
  assign bus.blk_idx      = out_cnt_q;
  assign bus.busy         = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done         = (state_q == DONE);

endmodule

// File: tb/tb_lambdar_barrier_sequencer.sv
// Scoreboard bench for lambdar_barrier_sequencer: driver issues runs, monitor checks against a block-level model.
module tb_lambdar_barrier_sequencer;

  localparam int NS = 4;
  localparam int NB = 16;
  localparam int CW = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lambdar_barrier_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  lambdar_barrier_sequencer #(
    .NUM_STAGES (NS),
    .NUM_BLOCKS (NB),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int idx;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  bit   lat_chk  = 1'b0;
  int   m_state  = M_IDLE;
  int   m_acc    = 0;
  int   m_out    = 0;
  bit   prev_stall = 1'b0;
  int   prev_blk   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Block-level model: blocks leave in acceptance order, NS cycles after acceptance when nothing stalls.
  always @(negedge clk) begin
    bit   stall, acc, ohs;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_state    = M_IDLE;
      m_acc      = 0;
      m_out      = 0;
      prev_stall = 1'b0;
    end else begin
      stall = bus.out_valid && !bus.out_ready;
      acc   = bus.in_valid && bus.in_ready;
      ohs   = bus.out_valid && bus.out_ready;
      chk("busy", int'(bus.busy), int'(m_state == M_RUN || m_state == M_DRAIN));
      chk("done", int'(bus.done), int'(m_state == M_DONE));
      chk("in_ready", int'(bus.in_ready), int'(m_state == M_RUN && !stall));
      chk("stage_enable0", int'(bus.stage_enable[0]),
          int'(bus.in_valid && m_state == M_RUN && !stall));
      if (stall) chk("stage_enable_stall", int'(bus.stage_enable), 0);
      if (prev_stall) chk("blk_idx_hold", int'(bus.blk_idx), prev_blk);
      if (lat_chk) chk("out_valid_timing", int'(bus.out_valid), int'(q.size() > 0 && q[0].due == cyc));
      if (ohs) begin
        if (q.size() == 0) begin
          chk("unexpected_output", int'(bus.blk_idx), -1);
        end else begin
          e = q.pop_front();
          chk("blk_idx", int'(bus.blk_idx), e.idx);
          if (lat_chk) chk("latency", cyc, e.due);
        end
        m_out++;
      end
      if (acc) begin
        q.push_back('{m_acc, cyc + NS});
        m_acc++;
      end
      if (bus.done) done_cnt++;
      case (m_state)
        M_IDLE: if (bus.start) begin
          m_state = M_RUN;
          m_acc   = 0;
          m_out   = 0;
        end
        M_RUN: begin
          if (m_out == NB)      m_state = M_DONE;
          else if (m_acc == NB) m_state = M_DRAIN;
        end
        M_DRAIN: if (m_out == NB) m_state = M_DONE;
        default: m_state = M_IDLE;
      endcase
      prev_stall = stall;
      prev_blk   = int'(bus.blk_idx);
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},     int'(bus.in_ready), 0);
    chk({tag, "_out_valid"},    int'(bus.out_valid), 0);
    chk({tag, "_stage_enable"}, int'(bus.stage_enable), 0);
    chk({tag, "_blk_idx"},      int'(bus.blk_idx), 0);
    chk({tag, "_busy"},         int'(bus.busy), 0);
    chk({tag, "_done"},         int'(bus.done), 0);
  endtask

  // vmode: 0 always valid, 1 alternate, 2 random. rmode: 0 always ready, 1 one 3-cycle stall, 2 random.
  task automatic do_run(input int vmode, input int rmode, input bit snoise);
    int d0;
    int n;
    int stall_left;
    bit stall_done;
    d0         = done_cnt;
    n          = 0;
    stall_left = 0;
    stall_done = 1'b0;
    lat_chk    = (rmode == 0);
    bus.start     = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    while (done_cnt == d0 && n < 3000) begin
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (n % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: begin
          if (!stall_done && n == 8) stall_left = 3;
          bus.out_ready = (stall_left == 0);
          if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) stall_done = 1'b1;
          end
        end
        default: bus.out_ready = ($urandom_range(0, 9) < 7);
      endcase
      bus.start = snoise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      n++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("run_completes", done_cnt - d0, 1);
    chk("blocks_out", m_out, NB);
    repeat (3) step();
    chk("one_done_per_run", done_cnt - d0, 1);
    lat_chk = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=%0d required=%0d", cyc, 0);
    $fatal(1);
  end

  initial begin
    int n;
    bus.start     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #2;
    check_zero("reset");
    repeat (3) step();
    check_zero("reset_hold");
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (5) step();
    chk("idle_no_start_busy", int'(bus.busy), 0);

    do_run(0, 0, 1'b0);
    do_run(0, 1, 1'b0);
    do_run(1, 0, 1'b0);

    bus.start = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.blk_idx != CW'(7) && n < 200) begin
      step();
      n++;
    end
    chk("reached_blk7", int'(bus.blk_idx), 7);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    step();
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    do_run(0, 0, 1'b0);

    do_run(0, 0, 1'b1);
    do_run(2, 2, 1'b1);
    for (int r = 0; r < 4; r++) begin
      do_run(2, 2, 1'($urandom_range(0, 1)));
      do_run(2, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
